// File: rtl/pmem_arbiter.sv
// Physical-memory arbiter: shares one line-wide memory port among NUM_PORTS cache clients.
// The winning request is latched on grant and held on the memory side until pmem_resp,
// then a one-cycle completion pulse is returned to that client only.
module pmem_arbiter #(
   parameter int unsigned NUM_PORTS     = 2,
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned LINE_WIDTH    = 256,
   parameter int unsigned PRIORITY_MODE = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             cli_read,
   input  logic [NUM_PORTS-1:0]             cli_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  cli_addr,
   input  logic [NUM_PORTS*LINE_WIDTH-1:0]  cli_wdata,
   output logic [NUM_PORTS-1:0]             cli_resp,
   output logic [LINE_WIDTH-1:0]            cli_rdata,
   output logic                             pmem_read,
   output logic                             pmem_write,
   output logic [ADDR_WIDTH-1:0]            pmem_addr,
   output logic [LINE_WIDTH-1:0]            pmem_wdata,
   input  logic [LINE_WIDTH-1:0]            pmem_rdata,
   input  logic                             pmem_resp,
   output logic                             busy,
   output logic [$clog2(NUM_PORTS)-1:0]     grant_id
);

   localparam int unsigned IdxW = $clog2(NUM_PORTS);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e                 r_state;
   logic [IdxW-1:0]        r_ptr;
   logic [IdxW-1:0]        r_grant_id;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [LINE_WIDTH-1:0]  r_wdata;
   logic [LINE_WIDTH-1:0]  r_rdata;
   logic                   r_pmem_read;
   logic                   r_pmem_write;
   logic                   r_busy;
   logic [NUM_PORTS-1:0]   r_cli_resp;

   logic [NUM_PORTS-1:0]   w_req;
   logic                   w_any_req;
   logic                   w_found;
   int unsigned            w_cand;
   logic [IdxW-1:0]        w_winner;
   logic [ADDR_WIDTH-1:0]  w_sel_addr;
   logic [LINE_WIDTH-1:0]  w_sel_wdata;
   logic                   w_sel_write;

   assign w_req     = cli_read | cli_write;
   assign w_any_req = |w_req;

   // Winner search: round-robin scans from the pointer, fixed priority scans from port 0.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_cand   = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (PRIORITY_MODE == 0) begin
            w_cand = (32'(r_ptr) + i) % NUM_PORTS;
         end else begin
            w_cand = i;
         end
         if (!w_found && w_req[IdxW'(w_cand)]) begin
            w_found  = 1'b1;
            w_winner = IdxW'(w_cand);
         end
      end
   end

   // Select the winning client's address, write line and operation (write wins over read).
   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_write = 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (IdxW'(i) == w_winner) begin
            w_sel_addr  = cli_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_sel_wdata = cli_wdata[i*LINE_WIDTH +: LINE_WIDTH];
            w_sel_write = cli_write[i];
         end
      end
   end

   // Arbitration FSM with registered memory-side and client-side outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= StIdle;
         r_ptr        <= '0;
         r_grant_id   <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_pmem_read  <= 1'b0;
         r_pmem_write <= 1'b0;
         r_busy       <= 1'b0;
         r_cli_resp   <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_any_req) begin
                  r_addr       <= w_sel_addr;
                  r_wdata      <= w_sel_wdata;
                  r_grant_id   <= w_winner;
                  r_pmem_write <= w_sel_write;
                  r_pmem_read  <= ~w_sel_write;
                  r_busy       <= 1'b1;
                  r_state      <= StBusy;
               end
            end
            StBusy: begin
               if (pmem_resp) begin
                  // Captured for writes too; the client ignores it then.
                  r_rdata      <= pmem_rdata;
                  r_pmem_read  <= 1'b0;
                  r_pmem_write <= 1'b0;
                  r_cli_resp   <= NUM_PORTS'(1) << r_grant_id;
                  if (PRIORITY_MODE == 0) begin
                     r_ptr <= (r_grant_id == IdxW'(NUM_PORTS - 1)) ? '0 : r_grant_id + 1'b1;
                  end
                  r_state      <= StDone;
               end
            end
            StDone: begin
               r_cli_resp <= '0;
               r_busy     <= 1'b0;
               r_state    <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign cli_resp   = r_cli_resp;
   assign cli_rdata  = r_rdata;
   assign pmem_read  = r_pmem_read;
   assign pmem_write = r_pmem_write;
   assign pmem_addr  = r_addr;
   assign pmem_wdata = r_wdata;
   assign busy       = r_busy;
   assign grant_id   = r_grant_id;

endmodule
